// File: rtl/tiny_bnn_seq.sv
// Tiny sequential binarized neural network.
// One hidden layer and one output layer of XNOR/popcount neurons. All
// weights and thresholds sit in a single serial scan chain. One neuron is
// evaluated per clock: hidden neurons first, then output neurons.
module tiny_bnn_seq #(
  parameter int INPUTS  = 8,
  parameter int HIDDEN  = 10,
  parameter int OUTPUTS = 8,
  // Derived sizes. They are parameters only so that the x_sel port width
  // can use them; do not override them.
  parameter int NB = INPUTS / 4,
  parameter int SW = (NB > 1) ? $clog2(NB) : 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               setup,
  input  logic               param_in,
  output logic               param_out,
  input  logic [3:0]         x_in,
  input  logic [SW-1:0]      x_sel,
  input  logic               x_we,
  input  logic               start,
  output logic               busy,
  output logic               out_valid,
  output logic [OUTPUTS-1:0] y
);

  localparam int TH   = $clog2(INPUTS + 1);
  localparam int TO   = $clog2(HIDDEN + 1);
  localparam int PH   = INPUTS + TH;
  localparam int PO   = HIDDEN + TO;
  localparam int L    = HIDDEN * PH + OUTPUTS * PO;
  localparam int OB   = HIDDEN * PH;
  localparam int CMAX = (HIDDEN > OUTPUTS) ? HIDDEN : OUTPUTS;
  localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HID  = 2'd1,
    OUT  = 2'd2
  } state_t;

  // Hidden-layer popcount. TH bits are enough to hold the value INPUTS.
  function automatic logic [TH-1:0] pop_h(input logic [INPUTS-1:0] v);
    logic [TH-1:0] acc;
    acc = '0;
    for (int i = 0; i < INPUTS; i++) begin
      acc = acc + TH'(v[i]);
    end
    return acc;
  endfunction

  // Output-layer popcount. TO bits are enough to hold the value HIDDEN.
  function automatic logic [TO-1:0] pop_o(input logic [HIDDEN-1:0] v);
    logic [TO-1:0] acc;
    acc = '0;
    for (int i = 0; i < HIDDEN; i++) begin
      acc = acc + TO'(v[i]);
    end
    return acc;
  endfunction

  logic [L-1:0]       chain_q, chain_d;
  logic [INPUTS-1:0]  x_q, x_d;
  logic [HIDDEN-1:0]  hid_q, hid_d;
  logic [OUTPUTS-1:0] shd_q, shd_d;
  logic [OUTPUTS-1:0] y_q, y_d;
  logic               valid_q, valid_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  state_t             state_q, state_d;

  logic [INPUTS-1:0]  hw_s;
  logic [TH-1:0]      ht_s;
  logic [HIDDEN-1:0]  ow_s;
  logic [TO-1:0]      ot_s;
  logic               hid_fire_s;
  logic               out_fire_s;

  assign param_out = chain_q[L-1];
  assign busy      = (state_q == HID) || (state_q == OUT);
  assign out_valid = valid_q;
  assign y         = y_q;

  // Select the parameters of the neuron addressed by cnt and compute its fire bit.
  always_comb begin
    hw_s = '0;
    ht_s = '0;
    ow_s = '0;
    ot_s = '0;
    for (int h = 0; h < HIDDEN; h++) begin
      if (cnt_q == CW'(h)) begin
        hw_s = chain_q[h*PH +: INPUTS];
        ht_s = chain_q[h*PH + INPUTS +: TH];
      end else begin
        hw_s = hw_s;
      end
    end
    for (int o = 0; o < OUTPUTS; o++) begin
      if (cnt_q == CW'(o)) begin
        ow_s = chain_q[OB + o*PO +: HIDDEN];
        ot_s = chain_q[OB + o*PO + HIDDEN +: TO];
      end else begin
        ow_s = ow_s;
      end
    end
    hid_fire_s = (pop_h(~(hw_s ^ x_q)) >= ht_s);
    out_fire_s = (pop_o(~(ow_s ^ hid_q)) >= ot_s);
  end

  // Next-state logic: setup mode overrides everything, otherwise run the FSM.
  always_comb begin
    chain_d = chain_q;
    x_d     = x_q;
    hid_d   = hid_q;
    shd_d   = shd_q;
    y_d     = y_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    state_d = state_q;

    if (setup) begin
      chain_d = {chain_q[L-2:0], param_in};
      x_d     = '0;
      valid_d = 1'b0;
      cnt_d   = '0;
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (x_we) begin
            for (int n = 0; n < NB; n++) begin
              if (x_sel == SW'(n)) begin
                x_d[4*n +: 4] = x_in;
              end else begin
                x_d[4*n +: 4] = x_q[4*n +: 4];
              end
            end
          end else begin
            x_d = x_q;
          end
          if (start) begin
            state_d = HID;
            cnt_d   = '0;
            valid_d = 1'b0;
          end else begin
            state_d = IDLE;
          end
        end
        HID: begin
          for (int h = 0; h < HIDDEN; h++) begin
            if (cnt_q == CW'(h)) begin
              hid_d[h] = hid_fire_s;
            end else begin
              hid_d[h] = hid_q[h];
            end
          end
          if (cnt_q == CW'(HIDDEN - 1)) begin
            state_d = OUT;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        OUT: begin
          for (int o = 0; o < OUTPUTS; o++) begin
            if (cnt_q == CW'(o)) begin
              shd_d[o] = out_fire_s;
            end else begin
              shd_d[o] = shd_q[o];
            end
          end
          if (cnt_q == CW'(OUTPUTS - 1)) begin
            state_d = IDLE;
            cnt_d   = '0;
            y_d     = shd_d;
            valid_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chain_q <= '0;
      x_q     <= '0;
      hid_q   <= '0;
      shd_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
      state_q <= IDLE;
    end else begin
      chain_q <= chain_d;
      x_q     <= x_d;
      hid_q   <= hid_d;
      shd_q   <= shd_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

endmodule
